deadtime_gate_drv: RTL

DEADTIME_GATE_DRV -- requirements
Module: deadtime_gate_drv

---
 rtl/deadtime_gate_drv_pkg.sv | 15 +
 rtl/deadtime_phase.sv | 93 +++++++++
 rtl/deadtime_gate_drv.sv | 86 ++++++++
 3 files changed

// File: rtl/deadtime_gate_drv_pkg.sv
// Shared types and defaults for the three-phase dead-time gate driver.
// Holds the per-phase FSM encoding and the parameter defaults used by top and phase.
package deadtime_gate_drv_pkg;

    typedef enum logic [1:0] {
        PH_OFF   = 2'd0,
        PH_DEAD  = 2'd1,
        PH_HI_ON = 2'd2,
        PH_LO_ON = 2'd3
    } phase_st_e;

    localparam int DEAD_CYCLES_DEF = 25;
    localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/deadtime_phase.sv
// One half-bridge leg: OFF/DEAD/HI_ON/LO_ON FSM with dead-time counter and overlap detect.
// Gate outputs are registered; request-to-gate latency from OFF is one cycle, no backpressure.
module deadtime_phase
    import deadtime_gate_drv_pkg::*;
#(
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic kill_i,
    input  logic restart_i,
    input  logic hi_req_i,
    input  logic lo_req_i,
    output logic hi_o,
    output logic lo_o,
    output logic ovl_o
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEAD_CYCLES - 1);

    phase_st_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hi_q, hi_d;
    logic             lo_q, lo_d;

    assign ovl_o = hi_req_i & lo_req_i;
    assign hi_o  = hi_q;
    assign lo_o  = lo_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= PH_DEAD;
            cnt_q   <= RELOAD;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // A fault clear restarts every leg with a full dead time, whatever it was doing.
        if (restart_i) begin
            state_d = PH_DEAD;
            cnt_d   = RELOAD;
        end else begin
            case (state_q)
                PH_OFF: begin
                    if (en_i && !kill_i) begin
                        if (hi_req_i && !lo_req_i) begin
                            state_d = PH_HI_ON;
                        end else if (lo_req_i && !hi_req_i) begin
                            state_d = PH_LO_ON;
                        end
                    end
                end
                PH_DEAD: begin
                    if (cnt_q == '0) begin
                        state_d = PH_OFF;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                PH_HI_ON: begin
                    if (!en_i || kill_i || !hi_req_i || lo_req_i) begin
                        state_d = PH_DEAD;
                        cnt_d   = RELOAD;
                    end
                end
                PH_LO_ON: begin
                    if (!en_i || kill_i || !lo_req_i || hi_req_i) begin
                        state_d = PH_DEAD;
                        cnt_d   = RELOAD;
                    end
                end
                default: begin
                    state_d = PH_DEAD;
                    cnt_d   = RELOAD;
                end
            endcase
        end
        hi_d = (state_d == PH_HI_ON);
        lo_d = (state_d == PH_LO_ON);
    end

endmodule

// File: rtl/deadtime_gate_drv.sv
// Three-phase gate driver: fault latch, qualified fault clear and enable fan-out around three legs.
// Gates follow requests one cycle after OFF; overlap faults blank all gates on the next cycle.
module deadtime_gate_drv
    import deadtime_gate_drv_pkg::*;
#(
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       A_in,
    input  logic       AA_in,
    input  logic       B_in,
    input  logic       BB_in,
    input  logic       C_in,
    input  logic       CC_in,
    input  logic       FAULT_CLR,
    output logic       A,
    output logic       AA,
    output logic       B,
    output logic       BB,
    output logic       C,
    output logic       CC,
    output logic       FAULT,
    output logic [2:0] FAULT_PH
);

    logic [2:0] hi_req, lo_req, hi_drv, lo_drv, ovl;
    logic       fault_q, fault_d;
    logic [2:0] fault_ph_q, fault_ph_d;
    logic       any_ovl, clr_ok, kill;

    assign hi_req  = {C_in, B_in, A_in};
    assign lo_req  = {CC_in, BB_in, AA_in};
    assign any_ovl = |ovl;
    // An overlap seen this cycle already blanks the gates, ahead of the latch catching up.
    assign kill    = fault_q | any_ovl;
    assign clr_ok  = FAULT_CLR & fault_q & ~any_ovl;

    for (genvar p = 0; p < 3; p++) begin : g_ph
        deadtime_phase #(
            .DEAD_CYCLES (DEAD_CYCLES),
            .CNT_W       (CNT_W)
        ) u_phase (
            .clk_i     (CLK),
            .rst_i     (RST),
            .en_i      (EN),
            .kill_i    (kill),
            .restart_i (clr_ok),
            .hi_req_i  (hi_req[p]),
            .lo_req_i  (lo_req[p]),
            .hi_o      (hi_drv[p]),
            .lo_o      (lo_drv[p]),
            .ovl_o     (ovl[p])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fault_q    <= 1'b0;
            fault_ph_q <= 3'b000;
        end else begin
            fault_q    <= fault_d;
            fault_ph_q <= fault_ph_d;
        end
    end

    always_comb begin
        fault_d    = fault_q;
        fault_ph_d = fault_ph_q;
        if (any_ovl) begin
            fault_d    = 1'b1;
            fault_ph_d = fault_ph_q | ovl;
        end else if (clr_ok) begin
            fault_d    = 1'b0;
            fault_ph_d = 3'b000;
        end
    end

    assign {C, B, A}    = hi_drv;
    assign {CC, BB, AA} = lo_drv;
    assign FAULT        = fault_q;
    assign FAULT_PH     = fault_ph_q;

endmodule
